// File: rtl/hex_display_scanner.sv
// Time-multiplexed scan controller for an N-digit hex display: drives one shared
// 7-segment decoder, walks the digit enables with blanking, and double-buffers the value.
module hex_display_scanner #(
  parameter int NUM_DIGITS       = 4,
  parameter int REFRESH_DIV      = 1000,
  parameter int BLANK_CYCLES     = 2,
  parameter bit ANODE_ACTIVE_LOW = 1'b1,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    lz_suppress,
  output logic [3:0]              dec_in,
  output logic                    dec_dot,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic [IW-1:0]           digit_idx,
  output logic                    frame_done,
  output logic                    upd_done
);

  localparam int CMAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] RD_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_t;

  localparam state_t FIRST_PHASE = (BLANK_CYCLES > 0) ? S_BLANK : S_SHOW;

  // Digit k (k>0) is a leading zero when every nibble from k upward is zero.
  function automatic logic digit_blanked(input logic [IW-1:0] k,
                                         input logic [4*NUM_DIGITS-1:0] v,
                                         input logic lz);
    logic upper_zero;
    upper_zero = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if ((j >= int'(k)) && (v[4*j +: 4] != 4'h0)) begin
        upper_zero = 1'b0;
      end else begin
        upper_zero = upper_zero;
      end
    end
    return lz && (k != {IW{1'b0}}) && upper_zero;
  endfunction

  state_t                  state_r, state_nxt;
  logic [CW-1:0]           cnt_r, cnt_nxt;
  logic [IW-1:0]           idx_r, idx_nxt;

  logic [4*NUM_DIGITS-1:0] act_val_r, act_val_nxt, pend_val_r, pend_val_nxt;
  logic [NUM_DIGITS-1:0]   act_dp_r, act_dp_nxt, pend_dp_r, pend_dp_nxt;
  logic                    act_lz_r, act_lz_nxt, pend_lz_r, pend_lz_nxt;
  logic                    pend_v_r, pend_v_nxt;

  logic [3:0]              dec_in_r, dec_in_nxt;
  logic                    dec_dot_r, dec_dot_nxt;
  logic [NUM_DIGITS-1:0]   digit_en_r, digit_en_nxt;
  logic [IW-1:0]           digit_idx_r, digit_idx_nxt;
  logic                    frame_done_r, frame_done_nxt;
  logic                    upd_done_r, upd_done_nxt;

  logic                    slot_end_s, boundary_s, apply_s, blank_s;
  logic [NUM_DIGITS-1:0]   onehot_s;

  assign slot_end_s = (state_r == S_SHOW) && (cnt_r == RD_LAST);
  assign boundary_s = enable && slot_end_s && (idx_r == IDX_LAST);
  // In IDLE there is no scan to tear, so a load goes straight to the active copy.
  assign apply_s    = ((state_r == S_IDLE) && load) || (boundary_s && (pend_v_r || load));

  // Scan sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      cnt_r   <= {CW{1'b0}};
      idx_r   <= {IW{1'b0}};
    end else begin
      state_r <= state_nxt;
      cnt_r   <= cnt_nxt;
      idx_r   <= idx_nxt;
    end
  end

  // Scan sequencer next state: IDLE -> BLANK -> SHOW per digit slot
  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    idx_nxt   = idx_r;
    if (!enable) begin
      state_nxt = S_IDLE;
      cnt_nxt   = {CW{1'b0}};
      idx_nxt   = {IW{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          state_nxt = FIRST_PHASE;
          cnt_nxt   = {CW{1'b0}};
          idx_nxt   = {IW{1'b0}};
        end
        S_BLANK: begin
          if (cnt_r == BLK_LAST) begin
            state_nxt = S_SHOW;
            cnt_nxt   = {CW{1'b0}};
          end else begin
            cnt_nxt = cnt_r + CW'(1);
          end
        end
        S_SHOW: begin
          if (slot_end_s) begin
            state_nxt = FIRST_PHASE;
            cnt_nxt   = {CW{1'b0}};
            idx_nxt   = (idx_r == IDX_LAST) ? {IW{1'b0}} : idx_r + IW'(1);
          end else begin
            cnt_nxt = cnt_r + CW'(1);
          end
        end
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = {CW{1'b0}};
          idx_nxt   = {IW{1'b0}};
        end
      endcase
    end
  end

  // Pending/active double buffer; a load at the boundary bypasses pending
  always_comb begin
    act_val_nxt  = act_val_r;
    act_dp_nxt   = act_dp_r;
    act_lz_nxt   = act_lz_r;
    pend_val_nxt = pend_val_r;
    pend_dp_nxt  = pend_dp_r;
    pend_lz_nxt  = pend_lz_r;
    pend_v_nxt   = pend_v_r;
    if (apply_s) begin
      if (load) begin
        act_val_nxt = value;
        act_dp_nxt  = dp_mask;
        act_lz_nxt  = lz_suppress;
      end else begin
        act_val_nxt = pend_val_r;
        act_dp_nxt  = pend_dp_r;
        act_lz_nxt  = pend_lz_r;
      end
      pend_v_nxt = 1'b0;
    end else if (load) begin
      pend_val_nxt = value;
      pend_dp_nxt  = dp_mask;
      pend_lz_nxt  = lz_suppress;
      pend_v_nxt   = 1'b1;
    end else begin
      pend_v_nxt = pend_v_r;
    end
  end

  // Output values for the cycle that follows this edge
  always_comb begin
    blank_s               = digit_blanked(idx_nxt, act_val_nxt, act_lz_nxt);
    onehot_s              = {NUM_DIGITS{1'b0}};
    onehot_s[idx_nxt]     = 1'b1;
    dec_in_nxt            = dec_in_r;
    dec_dot_nxt           = dec_dot_r;
    digit_idx_nxt         = digit_idx_r;
    if (state_nxt != S_IDLE) begin
      dec_in_nxt    = act_val_nxt[4*int'(idx_nxt) +: 4];
      dec_dot_nxt   = act_dp_nxt[idx_nxt] && !blank_s;
      digit_idx_nxt = idx_nxt;
    end else begin
      dec_in_nxt    = dec_in_r;
    end
    if ((state_nxt == S_SHOW) && !blank_s) begin
      digit_en_nxt = ANODE_ACTIVE_LOW ? ~onehot_s : onehot_s;
    end else begin
      digit_en_nxt = {NUM_DIGITS{ANODE_ACTIVE_LOW}};
    end
    frame_done_nxt = (state_nxt == S_SHOW) && (idx_nxt == IDX_LAST) && (cnt_nxt == RD_LAST);
    upd_done_nxt   = apply_s;
  end

  // Buffer and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_val_r    <= {(4*NUM_DIGITS){1'b0}};
      act_dp_r     <= {NUM_DIGITS{1'b0}};
      act_lz_r     <= 1'b0;
      pend_val_r   <= {(4*NUM_DIGITS){1'b0}};
      pend_dp_r    <= {NUM_DIGITS{1'b0}};
      pend_lz_r    <= 1'b0;
      pend_v_r     <= 1'b0;
      dec_in_r     <= 4'h0;
      dec_dot_r    <= 1'b0;
      digit_en_r   <= {NUM_DIGITS{ANODE_ACTIVE_LOW}};
      digit_idx_r  <= {IW{1'b0}};
      frame_done_r <= 1'b0;
      upd_done_r   <= 1'b0;
    end else begin
      act_val_r    <= act_val_nxt;
      act_dp_r     <= act_dp_nxt;
      act_lz_r     <= act_lz_nxt;
      pend_val_r   <= pend_val_nxt;
      pend_dp_r    <= pend_dp_nxt;
      pend_lz_r    <= pend_lz_nxt;
      pend_v_r     <= pend_v_nxt;
      dec_in_r     <= dec_in_nxt;
      dec_dot_r    <= dec_dot_nxt;
      digit_en_r   <= digit_en_nxt;
      digit_idx_r  <= digit_idx_nxt;
      frame_done_r <= frame_done_nxt;
      upd_done_r   <= upd_done_nxt;
    end
  end

  assign dec_in     = dec_in_r;
  assign dec_dot    = dec_dot_r;
  assign digit_en   = digit_en_r;
  assign digit_idx  = digit_idx_r;
  assign frame_done = frame_done_r;
  assign upd_done   = upd_done_r;

endmodule
